// File: rtl/code_capture_pkg.sv
// Shared types and constants for the code capture FIFO and its classifier.
package code_capture_pkg;

  localparam int unsigned CODE_W = 3;

  typedef enum logic [1:0] {IDLE, CAPTURE, DRAIN} cap_state_t;

  typedef struct packed {
    logic [CODE_W-1:0] code;
    logic              flag;
    logic              xz;
  } cap_entry_t;

endpackage

// File: rtl/code_capture_classify.sv
// Flags X/Z on the upstream code/flag pair and forces every unknown bit to 0.
module code_capture_classify
  import code_capture_pkg::*;
(
  input  logic [CODE_W-1:0] code,
  input  logic              flag,
  output cap_entry_t        entry
);

  always_comb begin
    entry      = '0;
    entry.xz   = $isunknown(^{code, flag});
    entry.flag = $isunknown(flag) ? 1'b0 : flag;
    for (int i = 0; i < int'(CODE_W); i++) begin
      entry.code[i] = $isunknown(code[i]) ? 1'b0 : code[i];
    end
  end

endmodule

// File: rtl/code_capture_fifo.sv
// Strobed capture of the upstream code/flag pair into a small FIFO with a valid/ready output.
// Define CODE_CAPTURE_FIFO_PARITY_EN to store per-entry parity and expose out_par_err.
module code_capture_fifo
  import code_capture_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic                    in_sample,
  input  logic [CODE_W-1:0]       in_code,
  input  logic                    in_flag,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [CODE_W-1:0]       out_code,
  output logic                    out_flag,
  output logic                    out_xz,
  output logic [$clog2(DEPTH):0]  level,
  output logic [CNT_W-1:0]        xz_count,
  output logic                    overflow,
  input  logic                    clr_overflow
`ifdef CODE_CAPTURE_FIFO_PARITY_EN
  ,
  output logic                    out_par_err
`endif
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  cap_state_t state;
  cap_entry_t entry;
  cap_entry_t head;
  cap_entry_t mem [DEPTH];

  logic [LW-1:0] wr_ptr, rd_ptr, wr_nxt, rd_nxt, level_nxt;
  logic          full, pop, push_req, push, drop, head_is_new;

  code_capture_classify u_classify (
    .code  (in_code),
    .flag  (in_flag),
    .entry (entry)
  );

  // A push into a full FIFO only lands when the head leaves in the same cycle.
  always_comb begin
    full        = (level == LW'(DEPTH));
    pop         = out_valid && out_ready && (state != IDLE);
    push_req    = (state == CAPTURE) && in_sample;
    push        = push_req && (!full || pop);
    drop        = push_req && full && !pop;
    wr_nxt      = wr_ptr + LW'(push);
    rd_nxt      = rd_ptr + LW'(pop);
    level_nxt   = level + LW'(push) - LW'(pop);
    head_is_new = push && (rd_nxt == wr_ptr);
    head        = head_is_new ? entry : mem[rd_nxt[AW-1:0]];
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= entry;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      out_valid <= 1'b0;
      out_code  <= '0;
      out_flag  <= 1'b0;
      out_xz    <= 1'b0;
      xz_count  <= '0;
      overflow  <= 1'b0;
    end else begin
      // Leaving CAPTURE/DRAIN looks at post-update occupancy so IDLE is always empty.
      case (state)
        IDLE:    if (en) state <= CAPTURE;
        CAPTURE: if (!en) state <= (level_nxt != '0) ? DRAIN : IDLE;
        DRAIN: begin
          if (en)                     state <= CAPTURE;
          else if (level_nxt == '0)   state <= IDLE;
        end
        default: state <= IDLE;
      endcase

      wr_ptr    <= wr_nxt;
      rd_ptr    <= rd_nxt;
      level     <= level_nxt;
      out_valid <= (level_nxt != '0);
      if (level_nxt != '0) begin
        out_code <= head.code;
        out_flag <= head.flag;
        out_xz   <= head.xz;
      end

      if (push && entry.xz && (xz_count != '1)) xz_count <= xz_count + CNT_W'(1);

      if (drop)              overflow <= 1'b1;
      else if (clr_overflow) overflow <= 1'b0;
    end
  end

`ifdef CODE_CAPTURE_FIFO_PARITY_EN
  logic mem_par [DEPTH];
  logic new_par, head_par;

  always_comb begin
    new_par  = ^{entry.code, entry.flag};
    head_par = head_is_new ? new_par : mem_par[rd_nxt[AW-1:0]];
  end

  always_ff @(posedge clk) begin
    if (push) mem_par[wr_ptr[AW-1:0]] <= new_par;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) out_par_err <= 1'b0;
    else        out_par_err <= (level_nxt != '0) && (head_par != ^{head.code, head.flag});
  end
`endif

endmodule

// File: tb/tb_code_capture_fifo.sv
// Self-checking bench for code_capture_fifo: directed vector table, corner sequences, random run vs queue model.
module tb_code_capture_fifo;

  localparam int unsigned DEPTH   = 4;
  localparam int unsigned CNT_W   = 8;
  localparam int unsigned CNT_MAX = (1 << CNT_W) - 1;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en, in_sample, in_flag, out_ready, clr_overflow;
  logic [2:0]  in_code;
  logic        out_valid, out_flag, out_xz, overflow;
  logic [2:0]  out_code;
  logic [2:0]  level;
  logic [7:0]  xz_count;
`ifdef CODE_CAPTURE_FIFO_PARITY_EN
  logic        out_par_err;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  code_capture_fifo #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .en           (en),
    .in_sample    (in_sample),
    .in_code      (in_code),
    .in_flag      (in_flag),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_code     (out_code),
    .out_flag     (out_flag),
    .out_xz       (out_xz),
    .level        (level),
    .xz_count     (xz_count),
    .overflow     (overflow),
    .clr_overflow (clr_overflow)
`ifdef CODE_CAPTURE_FIFO_PARITY_EN
    ,
    .out_par_err  (out_par_err)
`endif
  );

  // Behavioural reference: a queue of cleaned samples plus the capture mode.
  typedef struct {
    int code;
    int flag;
    int xz;
  } smp_t;
  typedef enum {M_IDLE, M_CAP, M_DRAIN} mode_t;

  smp_t  q[$];
  mode_t m_mode;
  int    m_cnt, m_ovf, m_code, m_flag, m_xz;

  task automatic model_reset();
    q.delete();
    m_mode = M_IDLE;
    m_cnt = 0; m_ovf = 0; m_code = 0; m_flag = 0; m_xz = 0;
  endtask

  task automatic model_cycle();
    smp_t s;
    logic p;
    bit   pop, acc, drop;
    pop  = (q.size() > 0) && (out_ready === 1'b1) && (m_mode != M_IDLE);
    acc  = (m_mode == M_CAP) && (in_sample === 1'b1);
    drop = acc && (q.size() == DEPTH) && !pop;
    if (drop) m_ovf = 1;
    else if (clr_overflow === 1'b1) m_ovf = 0;
    if (pop) void'(q.pop_front());
    if (acc && !drop) begin
      p      = ^{in_code, in_flag};
      s.xz   = ((p !== 1'b0) && (p !== 1'b1)) ? 1 : 0;
      s.code = 0;
      for (int i = 0; i < 3; i++) if (in_code[i] === 1'b1) s.code += (1 << i);
      s.flag = (in_flag === 1'b1) ? 1 : 0;
      q.push_back(s);
      if (s.xz == 1 && m_cnt < int'(CNT_MAX)) m_cnt++;
    end
    case (m_mode)
      M_IDLE:  if (en) m_mode = M_CAP;
      M_CAP:   if (!en) m_mode = (q.size() > 0) ? M_DRAIN : M_IDLE;
      default: if (en) m_mode = M_CAP; else if (q.size() == 0) m_mode = M_IDLE;
    endcase
    if (q.size() > 0) begin
      m_code = q[0].code; m_flag = q[0].flag; m_xz = q[0].xz;
    end
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    chk("out_valid", int'(out_valid), (q.size() > 0) ? 1 : 0);
    chk("level", int'(level), q.size());
    chk("out_code", int'(out_code), m_code);
    chk("out_flag", int'(out_flag), m_flag);
    chk("out_xz", int'(out_xz), m_xz);
    chk("xz_count", int'(xz_count), m_cnt);
    chk("overflow", int'(overflow), m_ovf);
`ifdef CODE_CAPTURE_FIFO_PARITY_EN
    chk("out_par_err", int'(out_par_err), 0);
`endif
  endtask

  // Drive one cycle of inputs, clock it, then compare against the model.
  task automatic step(input logic e, input logic s, input logic [2:0] c, input logic f,
                      input logic r, input logic cl);
    en = e; in_sample = s; in_code = c; in_flag = f; out_ready = r; clr_overflow = cl;
    model_cycle();
    @(posedge clk);
    #1;
    check_model();
  endtask

  typedef struct {
    logic       en, smp;
    logic [2:0] code;
    logic       flag, rdy, clr;
    int         v, lvl, oc, of, ox, ovf;
  } vec_t;

  vec_t tbl [22];

  initial begin
    logic [2:0] xcode;
    logic [2:0] c;

    tbl[0]  = '{1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 0, 0, 0, 0, 0, 0};
    tbl[1]  = '{1'b1, 1'b1, 3'd5, 1'b1, 1'b1, 1'b0, 1, 1, 5, 1, 0, 0};
    tbl[2]  = '{1'b1, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 0, 0, 5, 1, 0, 0};
    tbl[3]  = '{1'b1, 1'b1, 3'd1, 1'b0, 1'b0, 1'b0, 1, 1, 1, 0, 0, 0};
    tbl[4]  = '{1'b1, 1'b1, 3'd2, 1'b0, 1'b0, 1'b0, 1, 2, 1, 0, 0, 0};
    tbl[5]  = '{1'b1, 1'b1, 3'd3, 1'b0, 1'b0, 1'b0, 1, 3, 1, 0, 0, 0};
    tbl[6]  = '{1'b1, 1'b1, 3'd4, 1'b0, 1'b0, 1'b0, 1, 4, 1, 0, 0, 0};
    tbl[7]  = '{1'b1, 1'b1, 3'd6, 1'b0, 1'b0, 1'b0, 1, 4, 1, 0, 0, 1};
    tbl[8]  = '{1'b1, 1'b1, 3'd7, 1'b0, 1'b0, 1'b1, 1, 4, 1, 0, 0, 1};
    tbl[9]  = '{1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 1, 4, 1, 0, 0, 0};
    tbl[10] = '{1'b1, 1'b1, 3'd5, 1'b1, 1'b1, 1'b0, 1, 4, 2, 0, 0, 0};
    tbl[11] = '{1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1, 4, 2, 0, 0, 0};
    tbl[12] = '{1'b0, 1'b1, 3'd0, 1'b0, 1'b1, 1'b0, 1, 3, 3, 0, 0, 0};
    tbl[13] = '{1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 1, 2, 4, 0, 0, 0};
    tbl[14] = '{1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 1, 1, 5, 1, 0, 0};
    tbl[15] = '{1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 0, 0, 5, 1, 0, 0};
    tbl[16] = '{1'b0, 1'b1, 3'd3, 1'b0, 1'b0, 1'b0, 0, 0, 5, 1, 0, 0};
    tbl[17] = '{1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 0, 0, 5, 1, 0, 0};
    tbl[18] = '{1'b1, 1'b1, 3'd3, 1'b0, 1'b0, 1'b0, 1, 1, 3, 0, 0, 0};
    tbl[19] = '{1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1, 1, 3, 0, 0, 0};
    tbl[20] = '{1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1, 1, 3, 0, 0, 0};
    tbl[21] = '{1'b1, 1'b1, 3'd2, 1'b0, 1'b0, 1'b0, 1, 2, 3, 0, 0, 0};

    rst_n = 1'b0;
    en = 1'b0; in_sample = 1'b0; in_code = 3'd0; in_flag = 1'b0;
    out_ready = 1'b0; clr_overflow = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_model();
    rst_n = 1'b1;

    // Reset mid-stream: three buffered samples vanish as soon as rst_n falls.
    step(1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 3'd1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 3'd2, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 3'd7, 1'b1, 1'b0, 1'b0);
    chk("pre_reset_level", int'(level), 3);
    #3;
    rst_n = 1'b0;
    en = 1'b0; in_sample = 1'b0; clr_overflow = 1'b0;
    #1;
    chk("async_rst_level", int'(level), 0);
    chk("async_rst_valid", int'(out_valid), 0);
    chk("async_rst_xz_count", int'(xz_count), 0);
    chk("async_rst_overflow", int'(overflow), 0);
    chk("async_rst_out_code", int'(out_code), 0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Directed vectors: clean path, overflow and clear, full push+pop, drain and re-entry.
    for (int i = 0; i < 22; i++) begin
      step(tbl[i].en, tbl[i].smp, tbl[i].code, tbl[i].flag, tbl[i].rdy, tbl[i].clr);
      chk($sformatf("vec%0d_valid", i), int'(out_valid), tbl[i].v);
      chk($sformatf("vec%0d_level", i), int'(level), tbl[i].lvl);
      chk($sformatf("vec%0d_code", i), int'(out_code), tbl[i].oc);
      chk($sformatf("vec%0d_flag", i), int'(out_flag), tbl[i].of);
      chk($sformatf("vec%0d_xz", i), int'(out_xz), tbl[i].ox);
      chk($sformatf("vec%0d_ovf", i), int'(overflow), tbl[i].ovf);
    end

    // X/Z strobes: cleaned code, and the counter saturating after 300 samples.
    xcode = 3'b00x;
    for (int i = 0; i < 300; i++) step(1'b1, 1'b1, xcode, 1'b0, 1'b1, 1'b0);
    chk("xz_code_cleaned", int'(out_code), 0);
    chk("xz_count_after_300", int'(xz_count), m_cnt);

    // Random traffic with periodic enable-off windows to exercise drain.
    for (int i = 0; i < 3000; i++) begin
      c = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 7) == 0) c[$urandom_range(0, 2)] = 1'bz;
      step(((i % 100) < 80) ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 9) == 0),
           1'($urandom_range(0, 1)), c, 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 2) != 0), ($urandom_range(0, 15) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/code_capture_fifo.md
Name: code_capture_fifo

Overview:
- Downstream consumer of the 3-bit code / 1-bit flag pair produced by the gate-level stage (3-bit reg output plus 1-bit logic output).
- Samples the pair on a strobe and classifies each sample as clean 2-state or containing X/Z; X/Z-bearing code bits are cleaned to 0.
- Buffers samples in a small FIFO and presents them on a valid/ready stream, with a saturating X/Z counter and a sticky overflow flag.
- Turns the combinational, possibly 4-state output of the upstream stage into a clocked 2-state stream for the rest of the design.

Parameters:
- DEPTH, 4, number of FIFO entries; power of two, at least 2.
- CNT_W, 8, width of the saturating X/Z counter.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  capture enable; drives the FSM.
- in_sample  input  1  strobe: capture in_code/in_flag this cycle.
- in_code  input  3  code from the upstream stage (4-state).
- in_flag  input  1  flag from the upstream stage (4-state).
- out_valid  output  1  head entry available.
- out_ready  input  1  consumer accepts the head entry.
- out_code  output  3  head code, 2-state.
- out_flag  output  1  head flag, 2-state.
- out_xz  output  1  head sample contained X or Z.
- level  output  $clog2(DEPTH)+1  current occupancy.
- xz_count  output  CNT_W  saturating count of accepted X/Z samples.
- overflow  output  1  sticky: a sample was dropped because the FIFO was full.
- clr_overflow  input  1  synchronous clear of overflow.

Behaviour:
- Reset (async, rst_n=0):
  - FSM goes to IDLE; FIFO is emptied.
  - out_valid=0, out_code=0, out_flag=0, out_xz=0, level=0, xz_count=0, overflow=0.
  - Reset asserted mid-operation discards all buffered entries immediately.
- FSM:
  - IDLE -> CAPTURE when en=1.
  - CAPTURE -> DRAIN when en=0 and level!=0.
  - CAPTURE -> IDLE when en=0 and level==0.
  - DRAIN -> CAPTURE when en=1.
  - DRAIN -> IDLE when level reaches 0 with en=0.
  - Samples are accepted only in CAPTURE. Pops are allowed in CAPTURE and DRAIN. In IDLE, in_sample is ignored.
- Classification (combinational on the input side):
  - xz = reduction-XOR of {in_code, in_flag} is X.
  - Stored code/flag: each X/Z bit becomes 0; clean bits pass through unchanged.
- Push: in CAPTURE with in_sample=1. The entry is written at the rising edge, so out_valid rises 1 cycle after the strobe into an empty FIFO. Bypass is not allowed.
- Pop: out_valid && out_ready. The head advances at the edge.
- Outputs out_code/out_flag/out_xz are registered. When empty they hold the last popped values, or the reset values if nothing has been popped.
- Full with push and no pop: the sample is dropped; overflow<=1 and level is unchanged.
- Full with push and pop in the same cycle: both take effect; level stays DEPTH; no overflow.
- Empty with pop: impossible, because out_valid=0.
- Pointers wrap modulo DEPTH; an extra MSB distinguishes full from empty.
- xz_count increments only on an accepted push with xz=1 and saturates at 2^CNT_W-1. Dropped samples are not counted.
- overflow: if clr_overflow and a new overflow event occur in the same cycle, the set wins.
- level updates at the same edge as the push/pop that changes it.

Optional Feature:
- Macro: CODE_CAPTURE_FIFO_PARITY_EN.
- Defined:
  - Each entry stores an even-parity bit over {code,flag} computed at push.
  - Extra output out_par_err (1 bit) = head stored parity != recomputed parity, qualified by out_valid; reset value 0.
  - Corrupted entries are still delivered.
- Undefined: no parity storage, and the out_par_err port is absent.

Decomposition:
- Package code_capture_pkg holds:
  - typedef enum logic [1:0] {IDLE, CAPTURE, DRAIN} cap_state_t;
  - typedef struct packed {logic [2:0] code; logic flag; logic xz;} cap_entry_t;
  - localparam CODE_W = 3.
- One sub-module, code_capture_classify: combinational X/Z detection and cleaning, producing a cap_entry_t. The FIFO and FSM stay in the top module.

Test Plan:
- Reset mid-stream: push 3 samples, pulse rst_n low for 1 cycle -> level=0, out_valid=0, xz_count=0, overflow=0 asynchronously.
- Clean path: en=1, strobe in_code=3'b101, in_flag=1 with out_ready=1 -> out_valid high 1 cycle later with out_code=5, out_flag=1, out_xz=0, then empty.
- X/Z path: strobe in_code=3'b00x, in_flag=0 -> out_code=0, out_xz=1, xz_count=1. 300 such strobes with CNT_W=8 -> xz_count=255.
- Overflow: out_ready=0, 5 strobes at DEPTH=4 -> level=4, overflow=1, and the 5th sample is absent on drain. clr_overflow together with a 6th strobe -> overflow stays 1.
- Full push+pop: full FIFO, out_ready=1 and strobe in the same cycle -> level stays 4, overflow=0, order preserved.
- FSM drain: 3 entries buffered, en=0 -> state DRAIN, further strobes ignored, 3 pops, then IDLE. Reassert en during DRAIN -> back to CAPTURE.
